alu_4_arbiter: RTL
==================

ALU_4_ARBITER -- requirements
Module: alu_4_arbiter

Interface
REQ-001 Parameter: DATA_W, default 4, operand width; SHALL equal the alu_4 operand width (result width 2*DATA_W).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Ports: req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-005 Ports: req0_ready / req1_ready  output  1  operation of requester n accepted this cycle.
REQ-006 Ports: req0_a, req0_b / req1_a, req1_b  input  DATA_W  operands of requester n.
REQ-007 Ports: req0_op / req1_op  input  4  ALU control code of requester n.
REQ-008 Ports: rsp0_valid / rsp1_valid  output  1  result for requester n available.
REQ-009 Ports: rsp0_ready / rsp1_ready  input  1  requester n consumes result.
REQ-010 Port: rsp_y  output  2*DATA_W  result data, shared by both response channels.
REQ-011 Ports: alu_a, alu_b  output  DATA_W, and alu_ctrl  output  4  drive the shared alu_4 A, B, CTRL.
REQ-012 Port: alu_y  input  2*DATA_W  alu_4 Y, combinational from alu_a/alu_b/alu_ctrl.
REQ-013 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, RESP; transitions only IDLE->EXEC->RESP->IDLE.
REQ-015 IDLE: if any reqN_valid, grant one port, assert its reqN_ready combinationally that cycle, latch its a/b/op and grant id, go EXEC at the edge.
REQ-016 IDLE, no valid: remain IDLE; both req_ready low.
REQ-017 Arbitration: one valid -> that port; both valid -> port not equal to last_grant (round-robin).
REQ-018 last_grant SHALL update to the granted port at the RESP->IDLE edge.
REQ-019 req_ready SHALL be low in EXEC and RESP; a request arriving then waits, never dropped.
REQ-020 alu_a, alu_b, alu_ctrl SHALL always be driven from the operand registers (stable EXEC and RESP).
REQ-021 EXEC: capture alu_y into the result register at the edge, go RESP (one-cycle ALU slot).
REQ-022 RESP: rspN_valid high only for the granted port; rsp_y = result register; hold until rspN_ready high, then IDLE at that edge.
REQ-023 Latency: accept edge at cycle N -> rspN_valid high from cycle N+2; minimum 3 cycles per operation.
REQ-024 rsp_y and result register unchanged outside EXEC capture; rspN_ready ignored when rspN_valid low.
REQ-025 Simultaneous rspN_ready and new req_valid in RESP: response completes; new request accepted no earlier than next IDLE cycle.

Reset
REQ-026 On rst: state=IDLE, last_grant=1 (port 0 wins first contention), operand/op/result registers=0, all ready/valid outputs 0, busy=0.
REQ-027 rst mid-EXEC or mid-RESP SHALL abort the operation; no response is ever issued for it.

Configuration
REQ-028 Macro ALU_ARB_FIXED_PRIORITY_EN: defined -> port 0 always wins when both valid, last_grant unused; undefined -> round-robin per REQ-017.

Verification
(bench ALU model: alu_y = {alu_a, alu_b} for unique checking)
REQ-029 Reset asserted mid-RESP -> next cycle busy=0, rsp0_valid=rsp1_valid=0, rsp_y=8'h00.
REQ-030 req0 a=4'h3 b=4'h5 op=4'h2 alone, rsp0_ready=1 -> req0_ready at cycle 0, rsp0_valid at cycle 2, rsp_y=8'h35, alu_ctrl=4'h2.
REQ-031 Both valid continuously (a0=1,b0=1; a1=2,b1=2), responses always ready -> grants 0,1,0,1; rsp_y alternates 8'h11, 8'h22.
REQ-032 Same with ALU_ARB_FIXED_PRIORITY_EN defined -> grants 0,0,0; req1 starved while req0 valid.
REQ-033 rsp1_ready held low 5 cycles after rsp1_valid -> rsp1_valid, rsp_y, busy stable; req0_ready stays 0; req0 granted the cycle after rsp1 handshake edge.
REQ-034 req1 valid during EXEC of req0 -> req1_ready=0 until IDLE, then accepted; no lost or duplicated response.

Source files
------------

// File: rtl/alu_4_arbiter.sv
// alu_4_arbiter: two-requester front end sharing one combinational alu_4.
// Each operation walks IDLE -> EXEC -> RESP -> IDLE and occupies the ALU
// for exactly one cycle; the result is held until the granted requester
// consumes it.
// Optional macro ALU_ARB_FIXED_PRIORITY_EN: port 0 always wins contention
// (default build: round-robin against the last granted port).
module alu_4_arbiter #(
  parameter int unsigned DATA_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req1_valid,
  output logic                  req0_ready,
  output logic                  req1_ready,
  input  logic [DATA_W-1:0]     req0_a,
  input  logic [DATA_W-1:0]     req0_b,
  input  logic [DATA_W-1:0]     req1_a,
  input  logic [DATA_W-1:0]     req1_b,
  input  logic [3:0]            req0_op,
  input  logic [3:0]            req1_op,
  output logic                  rsp0_valid,
  output logic                  rsp1_valid,
  input  logic                  rsp0_ready,
  input  logic                  rsp1_ready,
  output logic [2*DATA_W-1:0]   rsp_y,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [3:0]            alu_ctrl,
  input  logic [2*DATA_W-1:0]   alu_y,
  output logic                  busy
);

  localparam int unsigned RES_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_q;
  logic                gnt_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [3:0]          op_q;
  logic [RES_W-1:0]    res_q;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
  logic                last_grant_q;
`endif

  logic                any_valid_c;
  logic                gnt_c;
  logic                rsp_ready_c;

  // Arbitration: a lone requester wins outright; contention resolved by policy.
  always_comb begin
    any_valid_c = req0_valid | req1_valid;
    gnt_c       = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
      gnt_c = 1'b0;
`else
      gnt_c = ~last_grant_q;
`endif
    end else begin
      gnt_c = req1_valid;
    end
    req0_ready  = (state_q == ST_IDLE) && any_valid_c && !gnt_c;
    req1_ready  = (state_q == ST_IDLE) && any_valid_c &&  gnt_c;
    rsp_ready_c = gnt_q ? rsp1_ready : rsp0_ready;
  end

  // Operation FSM: latch on accept, capture ALU in EXEC, hold result in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      res_q        <= '0;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_valid_c) begin
            gnt_q   <= gnt_c;
            a_q     <= gnt_c ? req1_a  : req0_a;
            b_q     <= gnt_c ? req1_b  : req0_b;
            op_q    <= gnt_c ? req1_op : req0_op;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_q   <= alu_y;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_c) begin
`ifndef ALU_ARB_FIXED_PRIORITY_EN
            last_grant_q <= gnt_q;
`endif
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Output decode straight from registered state.
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_ctrl   = op_q;
  assign rsp_y      = res_q;
  assign rsp0_valid = (state_q == ST_RESP) && !gnt_q;
  assign rsp1_valid = (state_q == ST_RESP) &&  gnt_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
